sha_digest_hex_tx: RTL

Downstream stage of the SHA-256 core. Accepts one 256-bit digest per valid pulse and converts it, MSB nibble first, to ASCII hex. It streams the characters, plus an optional line-feed terminator, byte by byte into the UART transmitter over its TxEn/TxDone handshake. This replaces ad-hoc buffer-to-string printing with a self-contained, back-pressured streaming block.

---
 rtl/sha_tx_pkg.sv | 17 +
 rtl/hex_nibble_ascii.sv | 19 +
 rtl/sha_digest_hex_tx.sv | 114 +++++++++++
 3 files changed

// File: rtl/sha_tx_pkg.sv
// Shared types and constants for the digest-to-ASCII-hex streaming path.
package sha_tx_pkg;

  // Streaming controller states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GAP      = 2'd1,
    WAIT_CLR = 2'd2,
    SEND     = 2'd3
  } tx_state_t;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_UA = 8'h41;

endpackage

// File: rtl/hex_nibble_ascii.sv
// Combinational 4-bit nibble to ASCII hex character; letter case is a parameter.
module hex_nibble_ascii
  import sha_tx_pkg::*;
#(
  parameter int UPPERCASE = 0
) (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  localparam logic [7:0] ALPHA_BASE = (UPPERCASE != 0) ? ASCII_UA : ASCII_LA;

  // Digits map from '0', letters from 'a' or 'A'
  always_comb begin
    if (nibble <= 4'd9) ascii = ASCII_0 + {4'd0, nibble};
    else                ascii = ALPHA_BASE + {4'd0, nibble} - 8'd10;
  end

endmodule

// File: rtl/sha_digest_hex_tx.sv
// Streams a captured digest as ASCII hex (MSB nibble first, optional LF)
// into a UART transmitter over a tx_en/tx_done byte handshake.
//
// Handshake: tx_en rises with tx_data already valid and both stay constant
// until tx_done is sampled high, which completes the byte and drops tx_en.
// tx_done is a level; a new byte is only offered once tx_done has returned
// low, so a done flag left over from the previous byte is never mistaken
// for completion of the next one.
module sha_digest_hex_tx
  import sha_tx_pkg::*;
#(
  parameter int DIGEST_W   = 256,
  parameter int CHAR_DELAY = 1000,
  parameter int UPPERCASE  = 0,
  parameter int APPEND_LF  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DIGEST_W-1:0] digest,
  input  logic                digest_valid,
  input  logic                tx_done,
  output logic                tx_en,
  output logic [7:0]          tx_data,
  output logic                busy,
  output logic                done,
  output logic                overrun,
  output logic [6:0]          char_idx,
  output tx_state_t           state
);

  localparam int HEX_CHARS = DIGEST_W / 4;
  localparam int N_CHARS   = HEX_CHARS + ((APPEND_LF != 0) ? 1 : 0);
  localparam logic [6:0] LAST_IDX = 7'(N_CHARS - 1);
  localparam logic [6:0] LF_IDX   = 7'(HEX_CHARS);
  localparam int CNT_W = (CHAR_DELAY < 1) ? 1 : $clog2(CHAR_DELAY + 1);
  localparam logic [CNT_W-1:0] DELAY_END = CNT_W'(CHAR_DELAY);

  logic [DIGEST_W-1:0] shreg;
  logic [CNT_W-1:0]    delay_cnt;
  logic [7:0]          nibble_char;
  logic [7:0]          cur_char;

  hex_nibble_ascii #(.UPPERCASE(UPPERCASE)) u_hex (
    .nibble (shreg[DIGEST_W-1 -: 4]),
    .ascii  (nibble_char)
  );

  // Character for the current index: the top nibble, or the terminator
  always_comb begin
    cur_char = nibble_char;
    if ((APPEND_LF != 0) && (char_idx == LF_IDX)) cur_char = ASCII_LF;
  end

  // Streaming controller: pacing gap, tx_done clear wait, byte in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      delay_cnt <= '0;
      char_idx  <= 7'd0;
      tx_en     <= 1'b0;
      tx_data   <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      done    <= 1'b0;
      // The done cycle still counts as busy for new requests
      overrun <= digest_valid && ((state != IDLE) || done);
      case (state)
        IDLE: begin
          if (digest_valid && !done) begin
            shreg     <= digest;
            char_idx  <= 7'd0;
            delay_cnt <= '0;
            busy      <= 1'b1;
            state     <= GAP;
          end
        end
        GAP: begin
          if (delay_cnt == DELAY_END) begin
            delay_cnt <= '0;
            state     <= WAIT_CLR;
          end else begin
            delay_cnt <= delay_cnt + CNT_W'(1);
          end
        end
        WAIT_CLR: begin
          if (!tx_done) begin
            tx_data <= cur_char;
            tx_en   <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          if (tx_done) begin
            tx_en <= 1'b0;
            if (char_idx == LAST_IDX) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              shreg    <= shreg << 4;
              char_idx <= char_idx + 7'd1;
              state    <= GAP;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
